// File: rtl/mem_port_arbiter_if.sv
// Bundle of client handshakes and memory strobes around mem_port_arbiter.
// master = clients + memory side, slave = arbiter side.
interface mem_port_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic          err0;
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic          err1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          mem_wr;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_dout,
    input  ack0, err0, ack1, err1, rdata, busy, mem_wr, mem_rd, mem_addr, mem_din
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_dout,
    output ack0, err0, ack1, err1, rdata, busy, mem_wr, mem_rd, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-client round-robin arbiter that serialises read/write requests into
// single-port memory strobe sequences, with range checking and registered outputs.
module mem_port_arbiter #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 11
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_e;

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic          prio_q, prio_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic          busy_q, busy_d;
  logic          mem_wr_q, mem_wr_d;
  logic          mem_rd_q, mem_rd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          win;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_ok;

  // prio_q names the requester that wins a tie; it flips to the loser on every grant
  always_comb begin
    win       = (bus.req0 && bus.req1) ? prio_q : bus.req1;
    sel_we    = win ? bus.we1    : bus.we0;
    sel_addr  = win ? bus.addr1  : bus.addr0;
    sel_wdata = win ? bus.wdata1 : bus.wdata0;
    sel_ok    = {1'b0, sel_addr} < DEPTH_W;
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    prio_d     = prio_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    mem_wr_d   = 1'b0;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rdata_d    = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d  = win;
          we_d   = sel_we;
          prio_d = ~win;
          if (sel_ok) begin
            state_d    = ISSUE;
            mem_wr_d   = sel_we;
            mem_rd_d   = ~sel_we;
            mem_addr_d = sel_addr;
            mem_din_d  = sel_wdata;
          end else begin
            state_d = ACK;
            ack0_d  = ~win;
            ack1_d  = win;
            err0_d  = ~win;
            err1_d  = win;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = ACK;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
        end else begin
          state_d  = CAPTURE;
          mem_rd_d = 1'b1;
        end
      end
      CAPTURE: begin
        // memory read data is registered, so it is valid during this cycle
        rdata_d = bus.mem_dout;
        state_d = ACK;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      prio_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      busy_q     <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      prio_q     <= prio_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      busy_q     <= busy_d;
      mem_wr_q   <= mem_wr_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.err0     = err0_q;
  assign bus.err1     = err1_q;
  assign bus.busy     = busy_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural 11x8 memory,
// request table plus collision, round-robin and reset-mid-read sequences.
module tb_mem_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  mem_port_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // single-port memory with registered read
  logic [DW-1:0] mem [0:DEPTH-1] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_wr && int'(bus.mem_addr) < DEPTH) mem[bus.mem_addr] <= bus.mem_din;
    if (bus.mem_rd && int'(bus.mem_addr) < DEPTH) bus.mem_dout <= mem[bus.mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          id;
    bit          err;
    bit          we;
    logic [7:0]  rdata;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    bit          id;
    bit          we;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    bit          err;
    logic [7:0]  rdata;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {5'd0, bus.ack0, bus.ack1, bus.err0, bus.err1, bus.busy, bus.mem_wr, bus.mem_rd,
            bus.mem_addr, bus.mem_din, bus.rdata};
  endfunction

  task automatic monitor();
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        wr_cnt = 0;
        rd_cnt = 0;
      end else begin
        if (bus.mem_wr) wr_cnt++;
        if (bus.mem_rd) rd_cnt++;
        chk("strobe_excl", {31'd0, bus.mem_wr & bus.mem_rd}, 0);
        if (bus.ack0 || bus.ack1) begin
          if (sbq.size() == 0) begin
            chk("unexpected_ack", {30'd0, bus.ack1, bus.ack0}, 0);
          end else begin
            e = sbq.pop_front();
            chk("ack_id", {30'd0, bus.ack1, bus.ack0}, e.id ? 2 : 1);
            chk("err", {30'd0, bus.err1, bus.err0}, e.err ? (e.id ? 2 : 1) : 0);
            chk("rdata", {24'd0, bus.rdata}, {24'd0, e.rdata});
            chk("busy_in_ack", {31'd0, bus.busy}, 1);
            if (e.lat > 0) chk("latency", cyc - e.t0, e.lat);
            chk("wr_cycles", wr_cnt, (!e.err && e.we) ? 1 : 0);
            chk("rd_cycles", rd_cnt, (!e.err && !e.we) ? 2 : 0);
          end
          wr_cnt = 0;
          rd_cnt = 0;
        end
      end
    end
  endtask

  task automatic single(input vec_t v);
    bit   got = 1'b0;
    exp_t e;
    @(negedge clk);
    if (v.id) begin
      bus.req1 = 1'b1; bus.we1 = v.we; bus.addr1 = v.addr; bus.wdata1 = v.wdata;
    end else begin
      bus.req0 = 1'b1; bus.we0 = v.we; bus.addr0 = v.addr; bus.wdata0 = v.wdata;
    end
    e = '{id: v.id, err: v.err, we: v.we, rdata: v.rdata, lat: v.lat, t0: cyc};
    sbq.push_back(e);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (v.id ? bus.ack1 : bus.ack0) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_timeout", {31'd0, got}, 1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_outs", all_outs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t tbl[10];
  exp_t e;
  bit   done0, done1;
  int   nacks;

  initial begin
    tbl[0] = '{0, 1, 4'd3,  8'hA5, 0, 8'h00, 2};
    tbl[1] = '{0, 0, 4'd3,  8'h00, 0, 8'hA5, 3};
    tbl[2] = '{1, 0, 4'd11, 8'h00, 1, 8'hA5, 1};
    tbl[3] = '{1, 0, 4'd15, 8'h00, 1, 8'hA5, 1};
    tbl[4] = '{1, 1, 4'd15, 8'h33, 1, 8'hA5, 1};
    tbl[5] = '{0, 1, 4'd10, 8'hFF, 0, 8'hA5, 2};
    tbl[6] = '{1, 0, 4'd10, 8'h00, 0, 8'hFF, 3};
    tbl[7] = '{0, 0, 4'd11, 8'h00, 1, 8'hFF, 1};
    tbl[8] = '{1, 1, 4'd0,  8'h5A, 0, 8'hFF, 2};
    tbl[9] = '{0, 0, 4'd0,  8'h00, 0, 8'h5A, 3};

    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

    fork
      monitor();
    join_none

    #1;
    chk("reset_outs_t0", all_outs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) single(tbl[i]);
    #1;
    chk("busy_idle_after_err", {31'd0, bus.busy}, 0);

    // collision straight after reset: requester 0 first, requester 1 after one IDLE cycle
    do_reset();
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd1; bus.wdata0 = 8'h11;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 4'd2; bus.wdata1 = 8'h22;
    e = '{id: 1'b0, err: 1'b0, we: 1'b1, rdata: 8'h00, lat: 2, t0: cyc};
    sbq.push_back(e);
    e = '{id: 1'b1, err: 1'b0, we: 1'b1, rdata: 8'h00, lat: 5, t0: cyc};
    sbq.push_back(e);
    done0 = 1'b0;
    done1 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.ack0) begin bus.req0 = 1'b0; done0 = 1'b1; end
      if (bus.ack1) begin bus.req1 = 1'b0; done1 = 1'b1; end
      if (done0 && done1) break;
    end
    chk("collision_timeout", {30'd0, done1, done0}, 3);
    @(posedge clk);

    // both requesters hold read requests: grants must alternate
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd1;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd2;
    for (int k = 0; k < 3; k++) begin
      e = '{id: 1'b0, err: 1'b0, we: 1'b0, rdata: 8'h11, lat: 0, t0: 0};
      sbq.push_back(e);
      e = '{id: 1'b1, err: 1'b0, we: 1'b0, rdata: 8'h22, lat: 0, t0: 0};
      sbq.push_back(e);
    end
    nacks = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) nacks++;
      if (nacks == 6) break;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk("rr_acks", nacks, 6);
    @(posedge clk);

    // reset during CAPTURE abandons the read with no ack
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_read_rd", {31'd0, bus.mem_rd}, 1);
    rst = 1'b0;
    #1;
    chk("mid_read_reset_outs", all_outs(), 0);
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("no_stray_ack", {30'd0, bus.ack1, bus.ack0}, 0);

    single('{0, 0, 4'd3, 8'h00, 0, 8'hA5, 3});
    single('{1, 1, 4'd13, 8'h77, 1, 8'hA5, 1});
    #1;
    chk("busy_idle_end", {31'd0, bus.busy}, 0);
    chk("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the 11 x 8-bit single-port data memory (4-bit address, wr/rd strobes, registered read data). It accepts a read or write request from each of two clients and serialises them into legal memory strobe sequences. It returns read data with a one-cycle ack pulse and rejects out-of-range addresses without touching the memory. It sits between the client logic and the memory; it is the only driver of the memory's wr/rd/addr/Datain.

Parameters:
DW, 8, data width
AW, 4, address width
DEPTH, 11, number of valid memory words; addresses >= DEPTH are out of range

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
req0  in  1  requester 0 request; held high until ack0
we0  in  1  requester 0: 1 = write, 0 = read; stable while req0 high
addr0  in  AW  requester 0 address; stable while req0 high
wdata0  in  DW  requester 0 write data; stable while req0 high
ack0  out  1  one-cycle completion pulse to requester 0
err0  out  1  valid with ack0; 1 = address out of range
req1, we1, addr1, wdata1, ack1, err1: same as above, for requester 1
rdata  out  DW  read result; valid in the ack cycle of a read, held until the next read completes
busy  out  1  high in any state other than IDLE
mem_wr  out  1  memory write strobe
mem_rd  out  1  memory read strobe
mem_addr  out  AW  memory address
mem_din  out  DW  memory write data
mem_dout  in  DW  memory read data

Behaviour:
- Reset (rst=0, async): state=IDLE. ack0, ack1, err0, err1, busy, mem_wr and mem_rd are 0. mem_addr, mem_din and rdata are 0. RR pointer favours requester 0. An in-flight transaction is abandoned with no ack.
- All outputs are registered. mem_wr and mem_rd are never high together.
- States: IDLE, ISSUE, CAPTURE, ACK.
- IDLE:
  - If no req, stay in IDLE.
  - Otherwise select the winner: the only requester, or if both are requesting, the one not granted last.
  - Latch grant, we, addr and wdata, and update the RR pointer.
  - If addr < DEPTH, go to ISSUE. Otherwise go to ACK with err set; no memory strobe.
- ISSUE (1 cycle): mem_addr and mem_din are driven. mem_wr=we and mem_rd=!we.
  - Write: go to ACK, with mem_wr low in ACK.
  - Read: go to CAPTURE.
- CAPTURE (read only, 1 cycle): mem_rd stays 1 and mem_addr is unchanged. At the closing edge, rdata <= mem_dout, then go to ACK.
- ACK (1 cycle): ack of the granted requester = 1. err = 1 only for out-of-range requests. Both strobes are 0. Next state is IDLE.
- rdata is unchanged by writes and errored requests.
- Latency, from the edge sampling req in IDLE to ack high:
  - write: 2 cycles
  - read: 3 cycles
  - error: 1 cycle
- IDLE lasts at least 1 cycle between transactions. A requester must drop req by the edge ending its ack cycle; a req still high in IDLE is treated as a new request.
- If req drops after grant, the transaction still completes and ack still pulses.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1...
- Requests arriving while busy wait; they are not lost as long as req is held.

Test Plan:
- Write then read: req0 write addr=3 wdata=0xA5 -> mem_wr high exactly 1 cycle, ack0 2 cycles after sample, err0=0. Then req0 read addr=3 -> mem_rd high 2 cycles, ack0 3 cycles after sample, rdata=0xA5.
- Collision after reset: req0 and req1 both write in the same cycle (addr 1=0x11, addr 2=0x22) -> requester 0 served first, then 1. Reads of 1 and 2 return 0x11 and 0x22.
- Round-robin: both requests held for 6 transactions -> ack order 0,1,0,1,0,1, with no two consecutive acks to the same requester.
- Out of range: req1 read addr=11, then addr=15 -> ack1 with err1=1 one cycle after sample, mem_wr=mem_rd=0 throughout, rdata unchanged.
- Reset mid-read: rst low during CAPTURE -> all outputs 0 immediately, no ack. After release, req0 read addr=3 completes normally.
- Held data: write addr=10 value 0xFF, then read addr=10 -> rdata=0xFF. Then an errored request -> rdata stays 0xFF and busy is low in IDLE.
